// File: rtl/banco_registradores.sv
// 32x32 register file for the multicycle MIPS datapath: one write port,
// two registered read ports, register 0 hardwired to zero.
module banco_registradores #(
  parameter logic [31:0] SP_RESET = 32'd227,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RegWrite,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic        WriteDone
);

  logic [31:0] regs_q [1:31];
  logic [31:0] rd1_d, rd1_q;
  logic [31:0] rd2_d, rd2_q;
  logic        done_d, done_q;
  logic        wr_en;

  assign wr_en  = RegWrite && (WriteReg != 5'd0);
  assign done_d = wr_en;

  // Index 0 has no storage, so both read muxes fall through to zero for it.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    for (int i = 1; i < 32; i++) begin
      if (ReadReg1 == 5'(i)) rd1_d = regs_q[i];
      if (ReadReg2 == 5'(i)) rd2_d = regs_q[i];
    end
    if (BYPASS && wr_en && (WriteReg == ReadReg1)) rd1_d = WriteData;
    if (BYPASS && wr_en && (WriteReg == ReadReg2)) rd2_d = WriteData;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= (i == 29) ? SP_RESET : 32'd0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wr_en && (WriteReg == 5'(i))) regs_q[i] <= WriteData;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd1_q  <= '0;
      rd2_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      done_q <= done_d;
    end
  end

  assign ReadData1 = rd1_q;
  assign ReadData2 = rd2_q;
  assign WriteDone = done_q;

endmodule

// File: tb/tb_banco_registradores.sv
// Scoreboard bench: runs a bypassing and a non-bypassing register file side by
// side against an array model of the architectural registers.
module tb_banco_registradores;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  write_reg, read_reg1, read_reg2;
  logic [31:0] write_data;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        done_b, done_n;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        done;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [32];

  always #5 clk = ~clk;

  banco_registradores #(.SP_RESET(32'd227), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset_n(rst_n), .RegWrite(reg_write), .WriteReg(write_reg),
    .WriteData(write_data), .ReadReg1(read_reg1), .ReadReg2(read_reg2),
    .ReadData1(rd1_b), .ReadData2(rd2_b), .WriteDone(done_b)
  );

  banco_registradores #(.SP_RESET(32'd227), .BYPASS(1'b0)) dut_nob (
    .clk(clk), .reset_n(rst_n), .RegWrite(reg_write), .WriteReg(write_reg),
    .WriteData(write_data), .ReadReg1(read_reg1), .ReadReg2(read_reg2),
    .ReadData1(rd1_n), .ReadData2(rd2_n), .WriteDone(done_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[29] = 32'd227;
  endfunction

  // Drive one cycle of stimulus and predict what both files present after the edge.
  task automatic cycle(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    logic acc;
    @(negedge clk);
    reg_write = we; write_reg = wr; write_data = wd;
    read_reg1 = r1; read_reg2 = r2;
    acc = we && (wr != 5'd0);
    e.rd1_n = (r1 == 5'd0) ? 32'd0 : mem[r1];
    e.rd2_n = (r2 == 5'd0) ? 32'd0 : mem[r2];
    e.rd1_b = (acc && wr == r1) ? wd : e.rd1_n;
    e.rd2_b = (acc && wr == r2) ? wd : e.rd2_n;
    e.done  = acc;
    sb_q.push_back(e);
    if (acc) mem[wr] = wd;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd1_byp"}, rd1_b, 32'd0);
    check({tag, "_rd2_byp"}, rd2_b, 32'd0);
    check({tag, "_rd1_nob"}, rd1_n, 32'd0);
    check({tag, "_rd2_nob"}, rd2_n, 32'd0);
    check({tag, "_done"}, {31'd0, done_b | done_n}, 32'd0);
  endtask

  // Pulse reset between edges; anything in flight is discarded.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    sb_q.delete();
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("rd1_byp", rd1_b, e.rd1_b);
      check("rd2_byp", rd2_b, e.rd2_b);
      check("rd1_nob", rd1_n, e.rd1_n);
      check("rd2_nob", rd2_n, e.rd2_n);
      check("done_byp", {31'd0, done_b}, {31'd0, e.done});
      check("done_nob", {31'd0, done_n}, {31'd0, e.done});
    end
  end

  initial begin
    rst_n = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    model_reset();

    // Reset asserted asynchronously mid-cycle, held across edges.
    #7 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    repeat (2) @(posedge clk);
    #3 check_reset_outputs("rst_held");
    #1 rst_n = 1'b1;

    cycle(1'b0, 5'd0, 32'd0, 5'd29, 5'd5);
    // Write to $ra then read it back one cycle later.
    cycle(1'b1, 5'd31, 32'hDEADBEEF, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    // Register 0 writes are discarded, including under bypass conditions.
    cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    // Same-edge write and read of reg 8.
    cycle(1'b1, 5'd8, 32'd5, 5'd0, 5'd0);
    cycle(1'b1, 5'd8, 32'd9, 5'd8, 5'd8);
    cycle(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
    // Back-to-back writes to one register.
    cycle(1'b1, 5'd4, 32'd1, 5'd4, 5'd0);
    cycle(1'b1, 5'd4, 32'd2, 5'd4, 5'd4);
    cycle(1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    // Write $sp, then reset mid-operation loses it.
    cycle(1'b1, 5'd29, 32'd7, 5'd29, 5'd29);
    cycle(1'b0, 5'd0, 32'd0, 5'd29, 5'd0);
    mid_reset("rst_mid");
    cycle(1'b0, 5'd0, 32'd0, 5'd29, 5'd8);

    // Sweep all registers, then read complementary pairs.
    for (int i = 1; i < 32; i++)
      cycle(1'b1, 5'(i), 32'(i * 3), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    for (int i = 1; i < 32; i++)
      cycle(1'b0, 5'd0, 32'd0, 5'(i), 5'(32 - i));

    // Random traffic; a narrow index range makes read/write collisions common.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] hi;
      hi = (n < 150) ? 5'd3 : 5'd31;
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, hi)), $urandom,
            5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)));
    end
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
